proc_run_ctrl: RTL and testbench

Parametrised run controller for the RISC processor's simulation and FPGA harness. It replaces the fixed "hold reset, then release" stimulus with a sequence driven from one clock:
- hold the core in reset for a programmable number of cycles;
- stream a program image into instruction memory through a valid/ready handshake;
- release the core and count cycles until it halts or a timeout expires;
- report status and cycle count.

It sits between the bench or host loader and the `processor` instance, driving the core's reset and the instruction-memory write port.

---
 rtl/proc_run_ctrl_if.sv | 24 ++
 rtl/proc_run_ctrl.sv | 179 +++++++++++++++++
 tb/tb_proc_run_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/proc_run_ctrl_if.sv
// Program-load and instruction-memory write bundle of the run controller.
// master = bench/host loader side, slave = controller side.
interface proc_run_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              prog_valid;
  logic              prog_ready;
  logic [DATA_W-1:0] prog_data;
  logic              prog_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;

  modport master (
    output prog_valid, prog_data, prog_last,
    input  prog_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  prog_valid, prog_data, prog_last,
    output prog_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/proc_run_ctrl.sv
// Run controller: holds the core in reset, streams a program image into
// instruction memory, then runs the core until halt or cycle limit.
module proc_run_ctrl #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int RST_CYCLES = 10,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               core_halt,
  proc_run_ctrl_if.slave     bus,
  output logic               core_rst,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic               error,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [ADDR_W:0]    words_loaded
);

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int LW     = ADDR_W + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [ADDR_W-1:0] PTR_MAX   = {ADDR_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(MAX_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RESET_HOLD = 3'd1,
    S_LOAD       = 3'd2,
    S_RUN        = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  state_t             state_r, state_s;
  logic [HOLD_W-1:0]  hold_cnt_r, hold_cnt_s;
  logic [ADDR_W-1:0]  ptr_r, ptr_s;
  logic               we_r, we_s;
  logic [ADDR_W-1:0]  addr_r, addr_s;
  logic [DATA_W-1:0]  wdata_r, wdata_s;
  logic               core_rst_r, core_rst_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic               timeout_r, timeout_s;
  logic               error_r, error_s;
  logic [CNT_W-1:0]   count_r, count_s;
  logic [LW-1:0]      loaded_r, loaded_s;
  logic               accept_s;

  assign bus.prog_ready = (state_r == S_LOAD);
  assign bus.imem_we    = we_r;
  assign bus.imem_addr  = addr_r;
  assign bus.imem_wdata = wdata_r;
  assign core_rst       = core_rst_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign timeout        = timeout_r;
  assign error          = error_r;
  assign cycle_count    = count_r;
  assign words_loaded   = loaded_r;

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_s    = state_r;
    hold_cnt_s = hold_cnt_r;
    ptr_s      = ptr_r;
    we_s       = 1'b0;
    addr_s     = addr_r;
    wdata_s    = wdata_r;
    done_s     = done_r;
    timeout_s  = timeout_r;
    error_s    = error_r;
    count_s    = count_r;
    loaded_s   = loaded_r;
    accept_s   = bus.prog_valid && (state_r == S_LOAD);

    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_s    = S_RESET_HOLD;
          hold_cnt_s = '0;
          ptr_s      = '0;
          done_s     = 1'b0;
          timeout_s  = 1'b0;
          error_s    = 1'b0;
          count_s    = '0;
          loaded_s   = '0;
        end else begin
          state_s = state_r;
        end
      end
      S_RESET_HOLD: begin
        if (hold_cnt_r == HOLD_LAST) begin
          state_s    = S_LOAD;
          hold_cnt_s = '0;
        end else begin
          hold_cnt_s = hold_cnt_r + HOLD_W'(1);
        end
      end
      S_LOAD: begin
        if (accept_s) begin
          we_s     = 1'b1;
          addr_s   = ptr_r;
          wdata_s  = bus.prog_data;
          ptr_s    = ptr_r + ADDR_W'(1);
          loaded_s = loaded_r + LW'(1);
          if (bus.prog_last) begin
            state_s = S_RUN;
          end else if (ptr_r == PTR_MAX) begin
            // Image does not fit: the last slot is still written, core stays in reset.
            state_s = S_DONE;
            error_s = 1'b1;
            done_s  = 1'b1;
          end else begin
            state_s = S_LOAD;
          end
        end else begin
          we_s = 1'b0;
        end
      end
      S_RUN: begin
        count_s = count_r + CNT_W'(1);
        if (core_halt) begin
          state_s = S_DONE;
          done_s  = 1'b1;
        end else if (count_s == CNT_LIMIT) begin
          state_s   = S_DONE;
          done_s    = 1'b1;
          timeout_s = 1'b1;
        end else begin
          state_s = S_RUN;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    core_rst_s = (state_s != S_RUN);
    busy_s     = (state_s == S_RESET_HOLD) || (state_s == S_LOAD) || (state_s == S_RUN);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      hold_cnt_r <= '0;
      ptr_r      <= '0;
      we_r       <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
      core_rst_r <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      timeout_r  <= 1'b0;
      error_r    <= 1'b0;
      count_r    <= '0;
      loaded_r   <= '0;
    end else begin
      state_r    <= state_s;
      hold_cnt_r <= hold_cnt_s;
      ptr_r      <= ptr_s;
      we_r       <= we_s;
      addr_r     <= addr_s;
      wdata_r    <= wdata_s;
      core_rst_r <= core_rst_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      timeout_r  <= timeout_s;
      error_r    <= error_s;
      count_r    <= count_s;
      loaded_r   <= loaded_s;
    end
  end

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Directed bench for proc_run_ctrl: default, short-limit and tiny-memory instances.
module tb_proc_run_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int pass_cnt  = 0;
  int total_cnt = 0;

  // Instance A: default parameters
  logic        start_a, halt_a, core_rst_a, busy_a, done_a, timeout_a, error_a;
  logic [31:0] cycles_a;
  logic [10:0] loaded_a;
  proc_run_ctrl_if #(.ADDR_W(10), .DATA_W(32)) bus_a ();
  proc_run_ctrl #(.ADDR_W(10), .DATA_W(32), .RST_CYCLES(10), .CNT_W(32), .MAX_CYCLES(100000)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .core_halt(halt_a), .bus(bus_a.slave),
    .core_rst(core_rst_a), .busy(busy_a), .done(done_a), .timeout(timeout_a),
    .error(error_a), .cycle_count(cycles_a), .words_loaded(loaded_a));

  // Instance B: MAX_CYCLES = 50
  logic        start_b, halt_b, core_rst_b, busy_b, done_b, timeout_b, error_b;
  logic [31:0] cycles_b;
  logic [4:0]  loaded_b;
  proc_run_ctrl_if #(.ADDR_W(4), .DATA_W(32)) bus_b ();
  proc_run_ctrl #(.ADDR_W(4), .DATA_W(32), .RST_CYCLES(2), .CNT_W(32), .MAX_CYCLES(50)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .core_halt(halt_b), .bus(bus_b.slave),
    .core_rst(core_rst_b), .busy(busy_b), .done(done_b), .timeout(timeout_b),
    .error(error_b), .cycle_count(cycles_b), .words_loaded(loaded_b));

  // Instance C: ADDR_W = 2 (four-word memory)
  logic        start_c, halt_c, core_rst_c, busy_c, done_c, timeout_c, error_c;
  logic [31:0] cycles_c;
  logic [2:0]  loaded_c;
  proc_run_ctrl_if #(.ADDR_W(2), .DATA_W(32)) bus_c ();
  proc_run_ctrl #(.ADDR_W(2), .DATA_W(32), .RST_CYCLES(2), .CNT_W(32), .MAX_CYCLES(100000)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .core_halt(halt_c), .bus(bus_c.slave),
    .core_rst(core_rst_c), .busy(busy_c), .done(done_c), .timeout(timeout_c),
    .error(error_c), .cycle_count(cycles_c), .words_loaded(loaded_c));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    total_cnt++; if (core_rst_a !== 1'b1) $display("FAIL reset_core_rst: got %0h want 1", core_rst_a); else pass_cnt++;
    total_cnt++; if (bus_a.imem_we !== 1'b0) $display("FAIL reset_we: got %0h want 0", bus_a.imem_we); else pass_cnt++;
    total_cnt++; if (bus_a.imem_addr !== 10'd0) $display("FAIL reset_addr: got %0h want 0", bus_a.imem_addr); else pass_cnt++;
    total_cnt++; if (bus_a.imem_wdata !== 32'd0) $display("FAIL reset_wdata: got %0h want 0", bus_a.imem_wdata); else pass_cnt++;
    total_cnt++; if ({busy_a, done_a, timeout_a, error_a} !== 4'b0000) $display("FAIL reset_flags: got %0b want 0000", {busy_a, done_a, timeout_a, error_a}); else pass_cnt++;
    total_cnt++; if (cycles_a !== 32'd0) $display("FAIL reset_cycles: got %0d want 0", cycles_a); else pass_cnt++;
    total_cnt++; if (loaded_a !== 11'd0) $display("FAIL reset_loaded: got %0d want 0", loaded_a); else pass_cnt++;
    total_cnt++; if (bus_a.prog_ready !== 1'b0) $display("FAIL reset_ready: got %0h want 0", bus_a.prog_ready); else pass_cnt++;
    rst = 1'b0;
    step();
    total_cnt++; if ({busy_a, core_rst_a} !== 2'b01) $display("FAIL idle_after_reset: got %0b want 01", {busy_a, core_rst_a}); else pass_cnt++;
  endtask

  task automatic test_reset_hold();
    int held;
    held = 0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    total_cnt++; if (busy_a !== 1'b1) $display("FAIL hold_busy: got %0h want 1", busy_a); else pass_cnt++;
    for (int i = 0; i < 9; i++) begin
      step();
      if (bus_a.prog_ready === 1'b0 && core_rst_a === 1'b1) held++;
    end
    total_cnt++; if (held !== 9) $display("FAIL hold_length: got %0d want 9", held); else pass_cnt++;
    step();
    total_cnt++; if (bus_a.prog_ready !== 1'b1) $display("FAIL hold_ready: got %0h want 1", bus_a.prog_ready); else pass_cnt++;
    total_cnt++; if (core_rst_a !== 1'b1) $display("FAIL hold_core_rst_in_load: got %0h want 1", core_rst_a); else pass_cnt++;
  endtask

  task automatic test_load_stream();
    logic [31:0] words [4];
    words[0] = 32'h13; words[1] = 32'h93; words[2] = 32'h113; words[3] = 32'h193;
    for (int k = 0; k < 4; k++) begin
      bus_a.prog_valid = 1'b1;
      bus_a.prog_data  = words[k];
      bus_a.prog_last  = (k == 3);
      step();
      total_cnt++; if ({bus_a.imem_we, bus_a.imem_addr} !== {1'b1, 10'(k)}) $display("FAIL stream_write%0d: got we=%0h addr=%0d want we=1 addr=%0d", k, bus_a.imem_we, bus_a.imem_addr, k); else pass_cnt++;
      total_cnt++; if (bus_a.imem_wdata !== words[k]) $display("FAIL stream_data%0d: got %0h want %0h", k, bus_a.imem_wdata, words[k]); else pass_cnt++;
    end
    bus_a.prog_valid = 1'b0;
    bus_a.prog_last  = 1'b0;
    total_cnt++; if (core_rst_a !== 1'b0) $display("FAIL stream_release: got core_rst=%0h want 0", core_rst_a); else pass_cnt++;
    total_cnt++; if (loaded_a !== 11'd4) $display("FAIL stream_loaded: got %0d want 4", loaded_a); else pass_cnt++;
  endtask

  task automatic test_halt_run();
    for (int i = 1; i <= 24; i++) begin
      start_a = (i == 5);
      step();
      if (i == 1) begin
        total_cnt++; if (bus_a.imem_we !== 1'b0) $display("FAIL run_we_drop: got %0h want 0", bus_a.imem_we); else pass_cnt++;
      end
    end
    start_a = 1'b0;
    total_cnt++; if ({busy_a, core_rst_a, cycles_a} !== {1'b1, 1'b0, 32'd24}) $display("FAIL run_busy_start: got busy=%0h core_rst=%0h cycles=%0d want 1 0 24", busy_a, core_rst_a, cycles_a); else pass_cnt++;
    halt_a = 1'b1;
    step();
    halt_a = 1'b0;
    total_cnt++; if ({done_a, timeout_a, core_rst_a, busy_a} !== 4'b1010) $display("FAIL halt_flags: got %0b want 1010", {done_a, timeout_a, core_rst_a, busy_a}); else pass_cnt++;
    total_cnt++; if (cycles_a !== 32'd25) $display("FAIL halt_cycles: got %0d want 25", cycles_a); else pass_cnt++;
    halt_a = 1'b1;
    step(); step();
    halt_a = 1'b0;
    total_cnt++; if ({done_a, cycles_a} !== {1'b1, 32'd25}) $display("FAIL done_hold: got done=%0h cycles=%0d want 1 25", done_a, cycles_a); else pass_cnt++;
  endtask

  task automatic test_bursty_load();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    total_cnt++; if ({done_a, cycles_a, loaded_a} !== {1'b0, 32'd0, 11'd0}) $display("FAIL restart_clear: got done=%0h cycles=%0d loaded=%0d want 0 0 0", done_a, cycles_a, loaded_a); else pass_cnt++;
    repeat (10) step();
    bus_a.prog_valid = 1'b1; bus_a.prog_data = 32'hA0; bus_a.prog_last = 1'b0;
    step();
    total_cnt++; if ({bus_a.imem_we, bus_a.imem_addr} !== {1'b1, 10'd0}) $display("FAIL burst_w0: got we=%0h addr=%0d want 1 0", bus_a.imem_we, bus_a.imem_addr); else pass_cnt++;
    bus_a.prog_valid = 1'b0; bus_a.prog_data = 32'hDEAD; bus_a.prog_last = 1'b1;
    step();
    total_cnt++; if (bus_a.imem_we !== 1'b0) $display("FAIL burst_stall1: got %0h want 0", bus_a.imem_we); else pass_cnt++;
    step();
    total_cnt++; if ({bus_a.imem_we, core_rst_a} !== 2'b01) $display("FAIL burst_stall2: got we=%0h core_rst=%0h want 0 1", bus_a.imem_we, core_rst_a); else pass_cnt++;
    bus_a.prog_valid = 1'b1; bus_a.prog_data = 32'hB0; bus_a.prog_last = 1'b1;
    step();
    bus_a.prog_valid = 1'b0; bus_a.prog_last = 1'b0;
    total_cnt++; if ({bus_a.imem_we, bus_a.imem_addr, bus_a.imem_wdata} !== {1'b1, 10'd1, 32'hB0}) $display("FAIL burst_w1: got we=%0h addr=%0d data=%0h want 1 1 b0", bus_a.imem_we, bus_a.imem_addr, bus_a.imem_wdata); else pass_cnt++;
    total_cnt++; if ({core_rst_a, loaded_a} !== {1'b0, 11'd2}) $display("FAIL burst_release: got core_rst=%0h loaded=%0d want 0 2", core_rst_a, loaded_a); else pass_cnt++;
    halt_a = 1'b1;
    step();
    halt_a = 1'b0;
    total_cnt++; if ({done_a, core_rst_a, cycles_a} !== {1'b1, 1'b1, 32'd1}) $display("FAIL first_cycle_halt: got done=%0h core_rst=%0h cycles=%0d want 1 1 1", done_a, core_rst_a, cycles_a); else pass_cnt++;
  endtask

  task automatic run_to_limit_b(input logic halt_last);
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    total_cnt++; if ({busy_b, done_b, timeout_b, cycles_b} !== {1'b1, 1'b0, 1'b0, 32'd0}) $display("FAIL b_start: got busy=%0h done=%0h to=%0h cycles=%0d want 1 0 0 0", busy_b, done_b, timeout_b, cycles_b); else pass_cnt++;
    step(); step();
    total_cnt++; if (bus_b.prog_ready !== 1'b1) $display("FAIL b_ready: got %0h want 1", bus_b.prog_ready); else pass_cnt++;
    bus_b.prog_valid = 1'b1; bus_b.prog_data = 32'h33; bus_b.prog_last = 1'b1;
    step();
    bus_b.prog_valid = 1'b0; bus_b.prog_last = 1'b0;
    repeat (49) step();
    total_cnt++; if ({done_b, cycles_b} !== {1'b0, 32'd49}) $display("FAIL b_pre_limit: got done=%0h cycles=%0d want 0 49", done_b, cycles_b); else pass_cnt++;
    halt_b = halt_last;
    step();
    halt_b = 1'b0;
  endtask

  task automatic test_timeout();
    run_to_limit_b(1'b0);
    total_cnt++; if ({done_b, timeout_b, core_rst_b} !== 3'b111) $display("FAIL timeout_flags: got %0b want 111", {done_b, timeout_b, core_rst_b}); else pass_cnt++;
    total_cnt++; if (cycles_b !== 32'd50) $display("FAIL timeout_cycles: got %0d want 50", cycles_b); else pass_cnt++;
  endtask

  task automatic test_halt_at_limit();
    run_to_limit_b(1'b1);
    total_cnt++; if ({done_b, timeout_b} !== 2'b10) $display("FAIL halt_wins: got %0b want 10", {done_b, timeout_b}); else pass_cnt++;
    total_cnt++; if (cycles_b !== 32'd50) $display("FAIL halt_wins_cycles: got %0d want 50", cycles_b); else pass_cnt++;
  endtask

  task automatic test_overflow();
    int released;
    released = 0;
    start_c = 1'b1;
    step();
    start_c = 1'b0;
    step(); step();
    bus_c.prog_valid = 1'b1; bus_c.prog_last = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus_c.prog_data = 32'(k + 1);
      step();
      if (core_rst_c !== 1'b1) released++;
      total_cnt++; if ({bus_c.imem_we, bus_c.imem_addr, bus_c.imem_wdata} !== {1'b1, 2'(k), 32'(k + 1)}) $display("FAIL ovf_write%0d: got we=%0h addr=%0d data=%0h", k, bus_c.imem_we, bus_c.imem_addr, bus_c.imem_wdata); else pass_cnt++;
    end
    total_cnt++; if ({error_c, done_c, busy_c, loaded_c} !== {1'b1, 1'b1, 1'b0, 3'd4}) $display("FAIL ovf_status: got err=%0h done=%0h busy=%0h loaded=%0d want 1 1 0 4", error_c, done_c, busy_c, loaded_c); else pass_cnt++;
    bus_c.prog_data = 32'd5;
    step();
    if (core_rst_c !== 1'b1) released++;
    bus_c.prog_valid = 1'b0;
    total_cnt++; if ({bus_c.imem_we, bus_c.prog_ready} !== 2'b00) $display("FAIL ovf_fifth_word: got we=%0h ready=%0h want 0 0", bus_c.imem_we, bus_c.prog_ready); else pass_cnt++;
    total_cnt++; if (released !== 0) $display("FAIL ovf_core_released: got %0d cycles want 0", released); else pass_cnt++;
  endtask

  task automatic test_rst_in_load();
    start_c = 1'b1;
    step();
    start_c = 1'b0;
    total_cnt++; if ({error_c, done_c} !== 2'b00) $display("FAIL c_restart_clear: got err=%0h done=%0h want 0 0", error_c, done_c); else pass_cnt++;
    step(); step();
    bus_c.prog_valid = 1'b1; bus_c.prog_data = 32'hAA; bus_c.prog_last = 1'b0;
    step();
    total_cnt++; if (bus_c.imem_we !== 1'b1) $display("FAIL c_pre_rst_write: got %0h want 1", bus_c.imem_we); else pass_cnt++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total_cnt++; if ({bus_c.imem_we, bus_c.prog_ready, core_rst_c, busy_c} !== 4'b0010) $display("FAIL c_rst_load: got we/ready/core_rst/busy=%0b want 0010", {bus_c.imem_we, bus_c.prog_ready, core_rst_c, busy_c}); else pass_cnt++;
    total_cnt++; if ({loaded_c, bus_c.imem_addr} !== 5'd0) $display("FAIL c_rst_counters: got loaded=%0d addr=%0d want 0 0", loaded_c, bus_c.imem_addr); else pass_cnt++;
    step();
    bus_c.prog_valid = 1'b0;
    total_cnt++; if (bus_c.imem_we !== 1'b0) $display("FAIL c_idle_ignores_prog: got %0h want 0", bus_c.imem_we); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; halt_a = 1'b0; start_b = 1'b0; halt_b = 1'b0; start_c = 1'b0; halt_c = 1'b0;
    bus_a.prog_valid = 1'b0; bus_a.prog_data = 32'd0; bus_a.prog_last = 1'b0;
    bus_b.prog_valid = 1'b0; bus_b.prog_data = 32'd0; bus_b.prog_last = 1'b0;
    bus_c.prog_valid = 1'b0; bus_c.prog_data = 32'd0; bus_c.prog_last = 1'b0;
    test_reset();
    test_reset_hold();
    test_load_stream();
    test_halt_run();
    test_bursty_load();
    test_timeout();
    test_halt_at_limit();
    test_overflow();
    test_rst_in_load();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
